// File: rtl/obi_pkg.sv
// Minimal OBI configuration package: the fields needed to size the relOBI A-channel sideband.
package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
    int unsigned AUserWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    AddrWidth:  32'd32,
    DataWidth:  32'd32,
    IdWidth:    32'd1,
    AUserWidth: 32'd0
  };

endpackage

// File: rtl/relobi_pkg.sv
// relOBI helpers: width of the A-channel "other" field and of its Hsiao SEC-DED check bits.
package relobi_pkg;

  // a_other = {we, be, aid, a_user}
  function automatic int unsigned relobi_a_other_width(obi_pkg::obi_cfg_t cfg);
    return 32'd1 + cfg.DataWidth / 32'd8 + cfg.IdWidth + cfg.AUserWidth;
  endfunction

  // Smallest r with 2^(r-1) >= k + r: enough odd-weight columns for SEC-DED.
  function automatic int unsigned hsiao_ecc_width(int unsigned k);
    int unsigned r;
    r = 0;
    for (int unsigned i = 2; i < 24; i++)
      if (r == 0 && (32'd1 << (i - 1)) >= k + i) r = i;
    return r;
  endfunction

  function automatic int unsigned relobi_a_other_ecc_width(obi_pkg::obi_cfg_t cfg);
    return hsiao_ecc_width(relobi_a_other_width(cfg));
  endfunction

endpackage

// File: rtl/relobi_a_ecc_cut.sv
// 2-entry cut on the relOBI A channel; a_other is SEC-DED checked/corrected on entry.
// Error counters exist only when RELOBI_ECC_STATS_EN is defined (otherwise tied to 0).
module relobi_a_ecc_cut #(
  parameter obi_pkg::obi_cfg_t Cfg     = obi_pkg::ObiDefaultConfig,
  parameter int unsigned       PlWidth = 64,
  localparam int unsigned      OW      = relobi_pkg::relobi_a_other_width(Cfg),
  localparam int unsigned      EW      = relobi_pkg::relobi_a_other_ecc_width(Cfg)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [PlWidth-1:0] pl_i,
  input  logic [OW-1:0]      other_i,
  input  logic [EW-1:0]      other_ecc_i,
  output logic               req_o,
  input  logic               gnt_i,
  output logic [PlWidth-1:0] pl_o,
  output logic [OW-1:0]      other_o,
  output logic [EW-1:0]      other_ecc_o,
  output logic               uncorr_o,
  output logic               err_corr_o,
  output logic               err_uncorr_o,
  input  logic               clr_cnt_i,
  output logic [15:0]        corr_cnt_o,
  output logic [15:0]        uncorr_cnt_o
);

  typedef logic [OW-1:0][EW-1:0] hmat_t;

  // Data columns: distinct odd-weight (>=3) vectors, lightest first; ECC columns are unit vectors.
  function automatic hmat_t hsiao_cols();
    hmat_t m;
    int    n;
    m = '0;
    n = 0;
    for (int w = 3; w <= int'(EW); w += 2)
      for (int v = 0; v < (1 << EW); v++)
        if ($countones(v) == w && n < int'(OW)) begin
          m[n] = EW'(v);
          n++;
        end
    return m;
  endfunction

  localparam hmat_t HCol = hsiao_cols();

  function automatic logic [EW-1:0] enc(logic [OW-1:0] d);
    logic [EW-1:0] e;
    e = '0;
    for (int i = 0; i < int'(OW); i++)
      if (d[i]) e = e ^ HCol[i];
    return e;
  endfunction

  typedef struct packed {
    logic [PlWidth-1:0] pl;
    logic [OW-1:0]      oth;
    logic [EW-1:0]      ecc;
    logic               unc;
  } ent_t;

  ent_t       mem_q [2];
  ent_t       new_ent;
  logic [1:0] cnt_q, cnt_d;
  logic       wptr_q, wptr_d, rptr_q, rptr_d;
  logic       err_corr_q, err_uncorr_q;
  logic       accept, pop;

  logic [EW-1:0] syn;
  logic [OW-1:0] flip, oth_fix;
  logic          ecc_hit, is_corr, is_unc;

  assign gnt_o  = (cnt_q != 2'd2);
  assign req_o  = (cnt_q != 2'd0);
  assign accept = req_i & gnt_o;
  assign pop    = req_o & gnt_i;

  always_comb begin
    syn     = enc(other_i) ^ other_ecc_i;
    flip    = '0;
    for (int i = 0; i < int'(OW); i++) flip[i] = (syn == HCol[i]);
    ecc_hit = $onehot(syn);
    is_corr = (^syn) & ((|flip) | ecc_hit);
    // Odd syndromes matching no column are multi-bit errors as well.
    is_unc  = (syn != '0) & ~is_corr;
    oth_fix = other_i ^ flip;

    new_ent     = '0;
    new_ent.pl  = pl_i;
    new_ent.oth = is_corr ? oth_fix : other_i;
    new_ent.ecc = is_corr ? enc(oth_fix) : other_ecc_i;
    new_ent.unc = is_unc;
  end

  always_comb begin
    cnt_d  = cnt_q;
    wptr_d = wptr_q ^ accept;
    rptr_d = rptr_q ^ pop;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= 2'd0;
      wptr_q       <= 1'b0;
      rptr_q       <= 1'b0;
      err_corr_q   <= 1'b0;
      err_uncorr_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      err_corr_q   <= accept & is_corr;
      err_uncorr_q <= accept & is_unc;
    end
  end

  // Entry storage carries no reset; its contents only matter while req_o is high.
  always_ff @(posedge clk_i) begin
    if (accept) mem_q[wptr_q] <= new_ent;
  end

  assign pl_o         = mem_q[rptr_q].pl;
  assign other_o      = mem_q[rptr_q].oth;
  assign other_ecc_o  = mem_q[rptr_q].ecc;
  assign uncorr_o     = req_o & mem_q[rptr_q].unc;
  assign err_corr_o   = err_corr_q;
  assign err_uncorr_o = err_uncorr_q;

`ifdef RELOBI_ECC_STATS_EN
  logic [15:0] corr_cnt_q, corr_cnt_d, uncorr_cnt_q, uncorr_cnt_d;

  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (clr_cnt_i) begin
      corr_cnt_d   = 16'd0;
      uncorr_cnt_d = 16'd0;
    end else begin
      if (accept && is_corr && corr_cnt_q != 16'hFFFF)  corr_cnt_d   = corr_cnt_q + 16'd1;
      if (accept && is_unc && uncorr_cnt_q != 16'hFFFF) uncorr_cnt_d = uncorr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      corr_cnt_q   <= 16'd0;
      uncorr_cnt_q <= 16'd0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_cnt_o   = corr_cnt_q;
  assign uncorr_cnt_o = uncorr_cnt_q;
`else
  logic unused_clr;
  assign unused_clr   = clr_cnt_i;
  assign corr_cnt_o   = 16'd0;
  assign uncorr_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_relobi_a_ecc_cut.sv
// Bench for relobi_a_ecc_cut: random codewords with injected flips vs a queue-based reference.
module tb_relobi_a_ecc_cut;

  localparam int unsigned PW = 64;
  localparam int unsigned OW = relobi_pkg::relobi_a_other_width(obi_pkg::ObiDefaultConfig);
  localparam int unsigned EW = relobi_pkg::relobi_a_other_ecc_width(obi_pkg::ObiDefaultConfig);

  typedef struct packed {
    logic [PW-1:0] pl;
    logic [OW-1:0] oth;
    logic [EW-1:0] ecc;
    logic          unc;
  } ent_t;

  logic          clk = 1'b0, rst = 1'b1, req = 1'b0, gi = 1'b0, clr = 1'b0;
  logic [PW-1:0] pl  = '0;
  logic [OW-1:0] oth = '0;
  logic [EW-1:0] ecc = '0;
  logic          gnt_o, req_o, uncorr_o, err_corr_o, err_uncorr_o;
  logic [PW-1:0] pl_o;
  logic [OW-1:0] other_o;
  logic [EW-1:0] other_ecc_o;
  logic [15:0]   corr_cnt_o, uncorr_cnt_o;

  int          checks = 0, failures = 0;
  ent_t        q[$];
  ent_t        cur_exp;
  int          cur_kind;
  bit          acc, m_ec, m_eu;
  logic [15:0] m_cc = '0, m_uc = '0;

  relobi_a_ecc_cut #(.PlWidth(PW)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_o), .pl_i(pl), .other_i(oth),
    .other_ecc_i(ecc), .req_o(req_o), .gnt_i(gi), .pl_o(pl_o), .other_o(other_o),
    .other_ecc_o(other_ecc_o), .uncorr_o(uncorr_o), .err_corr_o(err_corr_o),
    .err_uncorr_o(err_uncorr_o), .clr_cnt_i(clr), .corr_cnt_o(corr_cnt_o),
    .uncorr_cnt_o(uncorr_cnt_o)
  );

  always #5 clk = ~clk;

  // Hsiao code: data bit n uses the n-th odd-weight (>=3) vector ordered by weight then value.
  function automatic logic [EW-1:0] tb_enc(logic [OW-1:0] d);
    logic [EW-1:0] e;
    int n;
    e = '0;
    n = 0;
    for (int w = 3; w <= int'(EW); w += 2)
      for (int v = 0; v < (1 << EW); v++)
        if ($countones(v) == w) begin
          if (n < int'(OW)) begin
            if (d[n]) e = e ^ EW'(v);
          end
          n++;
        end
    return e;
  endfunction

  // kind 0 clean, 1 one flip at p0, 2 flips at p0/p1 (codeword index: ECC bits low, data above).
  task automatic new_item(input int kind, input int p0, input int p1);
    logic [OW+EW-1:0] cw;
    ent_t e;
    e.pl  = {$urandom, $urandom};
    e.oth = OW'($urandom);
    e.ecc = tb_enc(e.oth);
    e.unc = (kind == 2);
    cw = {e.oth, e.ecc};
    if (kind != 0) cw[p0] = ~cw[p0];
    if (kind == 2) cw[p1] = ~cw[p1];
    pl  = e.pl;
    oth = cw[OW+EW-1:EW];
    ecc = cw[EW-1:0];
    if (kind == 2) begin
      e.oth = oth;
      e.ecc = ecc;
    end
    cur_exp  = e;
    cur_kind = kind;
  endtask

  task automatic new_rand_item(input int kind);
    int p0, p1;
    p0 = int'($urandom_range(OW + EW - 1, 0));
    p1 = (p0 + 1 + int'($urandom_range(OW + EW - 2, 0))) % int'(OW + EW);
    new_item(kind, p0, p1);
  endtask

  // Advance the reference model by one clock edge and return to the falling edge.
  task automatic tick();
    bit r;
    acc = !rst && req && (q.size() < 2);
    r   = !rst && (q.size() != 0) && gi;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ec = 0;
      m_eu = 0;
      m_cc = '0;
      m_uc = '0;
    end else begin
      if (r) q.delete(0);
      if (acc) q.push_back(cur_exp);
      m_ec = acc && (cur_kind == 1);
      m_eu = acc && (cur_kind == 2);
`ifdef RELOBI_ECC_STATS_EN
      if (clr) begin
        m_cc = '0;
        m_uc = '0;
      end else begin
        if (m_ec && m_cc != 16'hFFFF) m_cc = m_cc + 16'd1;
        if (m_eu && m_uc != 16'hFFFF) m_uc = m_uc + 16'd1;
      end
`endif
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({req_o, gnt_o, err_corr_o, err_uncorr_o, uncorr_o, corr_cnt_o, uncorr_cnt_o} !== {1'b0, 1'b1, 3'b000, 32'd0}) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", {req_o, gnt_o, err_corr_o, err_uncorr_o, uncorr_o, corr_cnt_o, uncorr_cnt_o}, {1'b0, 1'b1, 3'b000, 32'd0});
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_stream();
    int sent = 0;
    new_rand_item(0);
    for (int c = 0; c < 8; c++) begin
      req = (sent < 4);
      gi  = 1'b1;
      checks++;
      if ({req_o, gnt_o, err_corr_o, err_uncorr_o, corr_cnt_o, uncorr_cnt_o} !== {q.size() != 0, q.size() != 2, m_ec, m_eu, m_cc, m_uc}) begin
        failures++;
        $display("FAIL clean_status got=%h exp=%h", {req_o, gnt_o, err_corr_o, err_uncorr_o, corr_cnt_o, uncorr_cnt_o}, {q.size() != 0, q.size() != 2, m_ec, m_eu, m_cc, m_uc});
      end
      if (q.size() != 0) begin
        checks++;
        if ({pl_o, other_o, other_ecc_o, uncorr_o} !== q[0]) begin
          failures++;
          $display("FAIL clean_head got=%h exp=%h", {pl_o, other_o, other_ecc_o, uncorr_o}, q[0]);
        end
      end
      tick();
      if (acc) begin
        sent++;
        new_rand_item(0);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_backpressure();
    int sent = 0;
    new_rand_item(0);
    for (int c = 0; c < 12; c++) begin
      gi  = (c >= 5);
      req = (sent < 3);
      checks++;
      if ({req_o, gnt_o, err_corr_o, err_uncorr_o, corr_cnt_o, uncorr_cnt_o} !== {q.size() != 0, q.size() != 2, m_ec, m_eu, m_cc, m_uc}) begin
        failures++;
        $display("FAIL bp_status cyc=%0d got=%h exp=%h", c, {req_o, gnt_o, err_corr_o, err_uncorr_o, corr_cnt_o, uncorr_cnt_o}, {q.size() != 0, q.size() != 2, m_ec, m_eu, m_cc, m_uc});
      end
      if (q.size() != 0) begin
        checks++;
        if ({pl_o, other_o, other_ecc_o, uncorr_o} !== q[0]) begin
          failures++;
          $display("FAIL bp_head cyc=%0d got=%h exp=%h", c, {pl_o, other_o, other_ecc_o, uncorr_o}, q[0]);
        end
      end
      tick();
      if (acc) begin
        sent++;
        new_rand_item(0);
      end
    end
    req = 1'b0;
    gi  = 1'b0;
  endtask

  // kind 1: first item flips a_other bit 0; kind 2: first item flips a_other bits 0 and 1.
  task automatic test_ecc_errors(input int kind);
    new_item(kind, int'(EW), int'(EW) + 1);
    for (int c = 0; c < 40; c++) begin
      req = (c % 2 == 0);
      gi  = 1'b1;
      checks++;
      if ({req_o, gnt_o, err_corr_o, err_uncorr_o, corr_cnt_o, uncorr_cnt_o} !== {q.size() != 0, q.size() != 2, m_ec, m_eu, m_cc, m_uc}) begin
        failures++;
        $display("FAIL ecc%0d_status cyc=%0d got=%h exp=%h", kind, c, {req_o, gnt_o, err_corr_o, err_uncorr_o, corr_cnt_o, uncorr_cnt_o}, {q.size() != 0, q.size() != 2, m_ec, m_eu, m_cc, m_uc});
      end
      if (q.size() != 0) begin
        checks++;
        if ({pl_o, other_o, other_ecc_o, uncorr_o} !== q[0]) begin
          failures++;
          $display("FAIL ecc%0d_head cyc=%0d got=%h exp=%h", kind, c, {pl_o, other_o, other_ecc_o, uncorr_o}, q[0]);
        end
      end
      tick();
      if (acc) new_rand_item(kind);
    end
    req = 1'b0;
  endtask

  task automatic test_random();
    new_rand_item(int'($urandom_range(2, 0)));
    for (int c = 0; c < 400; c++) begin
      req = 1'($urandom_range(1, 0));
      gi  = ($urandom_range(3, 0) != 0);
      clr = ($urandom_range(15, 0) == 0);
      checks++;
      if ({req_o, gnt_o, err_corr_o, err_uncorr_o, corr_cnt_o, uncorr_cnt_o} !== {q.size() != 0, q.size() != 2, m_ec, m_eu, m_cc, m_uc}) begin
        failures++;
        $display("FAIL rand_status cyc=%0d got=%h exp=%h", c, {req_o, gnt_o, err_corr_o, err_uncorr_o, corr_cnt_o, uncorr_cnt_o}, {q.size() != 0, q.size() != 2, m_ec, m_eu, m_cc, m_uc});
      end
      if (q.size() != 0) begin
        checks++;
        if ({pl_o, other_o, other_ecc_o, uncorr_o} !== q[0]) begin
          failures++;
          $display("FAIL rand_head cyc=%0d got=%h exp=%h", c, {pl_o, other_o, other_ecc_o, uncorr_o}, q[0]);
        end
      end
      tick();
      if (acc) new_rand_item(int'($urandom_range(2, 0)));
    end
    req = 1'b0;
    clr = 1'b0;
    gi  = 1'b1;
    tick();
    tick();
  endtask

  // Three corrected errors from a preloaded 0xFFFE, then a clear coinciding with a fourth.
  task automatic test_saturation();
`ifdef RELOBI_ECC_STATS_EN
    force dut.corr_cnt_q = 16'hFFFE;
    #1 release dut.corr_cnt_q;
    m_cc = 16'hFFFE;
`endif
    gi = 1'b1;
    new_rand_item(1);
    for (int c = 0; c < 7; c++) begin
      req = (c < 4);
      clr = (c == 3);
      checks++;
      if ({req_o, gnt_o, err_corr_o, err_uncorr_o, corr_cnt_o, uncorr_cnt_o} !== {q.size() != 0, q.size() != 2, m_ec, m_eu, m_cc, m_uc}) begin
        failures++;
        $display("FAIL sat_status cyc=%0d got=%h exp=%h", c, {req_o, gnt_o, err_corr_o, err_uncorr_o, corr_cnt_o, uncorr_cnt_o}, {q.size() != 0, q.size() != 2, m_ec, m_eu, m_cc, m_uc});
      end
      tick();
      if (acc) new_rand_item(1);
    end
    req = 1'b0;
    clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    gi  = 1'b0;
    req = 1'b1;
    new_rand_item(2);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (acc) new_rand_item(1);
    end
    checks++;
    if (q.size() != 2 || gnt_o !== 1'b0 || req_o !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_full got=%b%b exp=01 model=%0d", gnt_o, req_o, q.size());
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 1'b0;
    checks++;
    if ({req_o, gnt_o, err_corr_o, err_uncorr_o, uncorr_o, corr_cnt_o, uncorr_cnt_o} !== {1'b0, 1'b1, 3'b000, 32'd0}) begin
      failures++;
      $display("FAIL rstmid got=%h exp=%h", {req_o, gnt_o, err_corr_o, err_uncorr_o, uncorr_o, corr_cnt_o, uncorr_cnt_o}, {1'b0, 1'b1, 3'b000, 32'd0});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_stream();
    test_backpressure();
    test_ecc_errors(1);
    test_ecc_errors(2);
    test_random();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
